// File: rtl/vmem_write_arbiter.sv
// rtl/vmem_write_arbiter.sv - video memory write-port arbiter: CPU writes vs. hardware fill engine
// Optional feature: define VMEM_STALL_CNT_EN to add the 16-bit saturating stall_cnt output.
module vmem_write_arbiter #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_data,
  output logic              cpu_ack,
  input  logic              fill_start,
  input  logic [ADDR_W-1:0] fill_base,
  input  logic [ADDR_W-1:0] fill_len,
  input  logic [DATA_W-1:0] fill_color,
  output logic              fill_busy,
  output logic              fill_done,
  output logic              web,
  output logic [ADDR_W-1:0] addrb,
  output logic [DATA_W-1:0] datab
`ifdef VMEM_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  // One extra bit so a full-memory fill (len+1 = 2^ADDR_W) fits in the counter.
  localparam int CNT_W = ADDR_W + 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_FILL = 1'b1
  } state_t;

  // Who owned the write port in the previous cycle; drives CPU/fill alternation.
  typedef enum logic [1:0] {
    G_NONE = 2'd0,
    G_CPU  = 2'd1,
    G_FILL = 2'd2
  } grant_t;

  state_t             state;
  state_t             state_n;
  grant_t             last_grant;
  logic [ADDR_W-1:0]  fill_addr;
  logic [DATA_W-1:0]  fill_data;
  logic [CNT_W-1:0]   fill_count;

  logic cpu_elig;
  logic cpu_grant;
  logic fill_grant;
  logic fill_accept;
  logic fill_last;

  // A CPU request is not eligible in its own ack cycle, so a held request
  // can never be written twice.
  assign cpu_elig = cpu_req & ~cpu_ack;

  // fill_busy is simply the FILL state; it falls on the edge that registers
  // the final fill write, together with fill_done.
  assign fill_busy = (state == S_FILL);

  // Next-state and grant decision for the current cycle.
  always_comb begin
    state_n     = state;
    cpu_grant   = 1'b0;
    fill_grant  = 1'b0;
    fill_accept = 1'b0;
    fill_last   = 1'b0;
    case (state)
      S_IDLE: begin
        // CPU always wins in IDLE; a simultaneous fill command is still latched
        // and starts competing from the next cycle.
        cpu_grant = cpu_elig;
        if (fill_start) begin
          fill_accept = 1'b1;
          state_n     = S_FILL;
        end
      end
      S_FILL: begin
        // Strict alternation with CPU priority: the CPU yields only if it
        // owned the port last cycle. fill_start is ignored here.
        if (cpu_elig && (last_grant != G_CPU)) begin
          cpu_grant = 1'b1;
        end else begin
          fill_grant = 1'b1;
        end
        fill_last = fill_grant && (fill_count == CNT_W'(1));
        if (fill_last) begin
          state_n = S_IDLE;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Fill engine context: latched on command, advanced on each fill grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_addr  <= '0;
      fill_data  <= '0;
      fill_count <= '0;
    end else if (fill_accept) begin
      fill_addr  <= fill_base;
      fill_data  <= fill_color;
      fill_count <= {1'b0, fill_len} + CNT_W'(1);
    end else if (fill_grant) begin
      // Address wraps naturally modulo 2^ADDR_W.
      fill_addr  <= fill_addr + ADDR_W'(1);
      fill_count <= fill_count - CNT_W'(1);
    end
  end

  // Previous-cycle owner of the write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= G_NONE;
    end else if (cpu_grant) begin
      last_grant <= G_CPU;
    end else if (fill_grant) begin
      last_grant <= G_FILL;
    end else begin
      last_grant <= G_NONE;
    end
  end

  // Registered memory write port and handshake pulses; address/data hold
  // their last values when nobody is granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      web       <= 1'b0;
      addrb     <= '0;
      datab     <= '0;
      cpu_ack   <= 1'b0;
      fill_done <= 1'b0;
    end else begin
      web       <= cpu_grant | fill_grant;
      cpu_ack   <= cpu_grant;
      fill_done <= fill_last;
      if (cpu_grant) begin
        addrb <= cpu_addr;
        datab <= cpu_data;
      end else if (fill_grant) begin
        addrb <= fill_addr;
        datab <= fill_data;
      end
    end
  end

`ifdef VMEM_STALL_CNT_EN
  // Cycles in which the CPU asks (outside its ack cycle) but is not granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (cpu_req && !cpu_ack && !cpu_grant && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vmem_write_arbiter.sv
// tb/tb_vmem_write_arbiter.sv - directed self-checking bench for vmem_write_arbiter
module tb_vmem_write_arbiter;

  logic        clk;
  logic        rst_n;
  logic        cpu_req;
  logic [12:0] cpu_addr;
  logic [23:0] cpu_data;
  logic        cpu_ack;
  logic        fill_start;
  logic [12:0] fill_base;
  logic [12:0] fill_len;
  logic [23:0] fill_color;
  logic        fill_busy;
  logic        fill_done;
  logic        web;
  logic [12:0] addrb;
  logic [23:0] datab;
`ifdef VMEM_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int errors;
  int checks;

  vmem_write_arbiter #(.ADDR_W(13), .DATA_W(24)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_req    (cpu_req),
    .cpu_addr   (cpu_addr),
    .cpu_data   (cpu_data),
    .cpu_ack    (cpu_ack),
    .fill_start (fill_start),
    .fill_base  (fill_base),
    .fill_len   (fill_len),
    .fill_color (fill_color),
    .fill_busy  (fill_busy),
    .fill_done  (fill_done),
    .web        (web),
    .addrb      (addrb),
    .datab      (datab)
`ifdef VMEM_STALL_CNT_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({web, cpu_ack, fill_busy, fill_done, addrb, datab} !== 41'd0) begin
      errors++;
      $display("FAIL reset_state got web=%0b ack=%0b busy=%0b done=%0b addrb=%h datab=%h exp all zero",
               web, cpu_ack, fill_busy, fill_done, addrb, datab);
    end
`ifdef VMEM_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_stall got=%0d exp=0", stall_cnt);
    end
`endif
    rst_n = 1'b1;
  endtask

  // Request placed on the same negedge reset is released: grant on first edge.
  task automatic test_cpu_only;
    cpu_req  = 1'b1;
    cpu_addr = 13'h0010;
    cpu_data = 24'hABCDEF;
    @(negedge clk);
    checks++;
    if ({web, cpu_ack, addrb, datab} !== {1'b1, 1'b1, 13'h0010, 24'hABCDEF}) begin
      errors++;
      $display("FAIL cpu_write got web=%0b ack=%0b addrb=%h datab=%h exp 1 1 0010 abcdef",
               web, cpu_ack, addrb, datab);
    end
    cpu_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({web, cpu_ack, addrb, datab} !== {1'b0, 1'b0, 13'h0010, 24'hABCDEF}) begin
      errors++;
      $display("FAIL cpu_hold got web=%0b ack=%0b addrb=%h datab=%h exp 0 0 0010 abcdef",
               web, cpu_ack, addrb, datab);
    end
  endtask

  task automatic test_fill_wrap;
    logic [12:0] ea;
    fill_start = 1'b1;
    fill_base  = 13'h1FFE;
    fill_len   = 13'd3;
    fill_color = 24'h00FF00;
    @(negedge clk);
    fill_start = 1'b0;
    checks++;
    if ({web, fill_busy} !== 2'b01) begin
      errors++;
      $display("FAIL fill_latch got web=%0b busy=%0b exp web=0 busy=1", web, fill_busy);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      ea = 13'h1FFE + k[12:0];
      checks++;
      if ({web, addrb, datab, fill_done, fill_busy, cpu_ack} !==
          {1'b1, ea, 24'h00FF00, (k == 3), (k != 3), 1'b0}) begin
        errors++;
        $display("FAIL fill_wrap[%0d] got web=%0b addrb=%h datab=%h done=%0b busy=%0b exp addrb=%h done=%0b",
                 k, web, addrb, datab, fill_done, fill_busy, ea, (k == 3));
      end
    end
    @(negedge clk);
    checks++;
    if ({web, fill_done, fill_busy, addrb} !== {3'b000, 13'h0001}) begin
      errors++;
      $display("FAIL fill_after got web=%0b done=%0b busy=%0b addrb=%h exp 0 0 0 0001",
               web, fill_done, fill_busy, addrb);
    end
  endtask

  // Fill command and CPU request arrive together in IDLE, CPU then held.
  task automatic test_contention;
    int ncpu;
    int acks;
    int j;
    ncpu = 0;
    acks = 0;
    cpu_req    = 1'b1;
    cpu_addr   = 13'h0200;
    cpu_data   = 24'h100000;
    fill_start = 1'b1;
    fill_base  = 13'h0100;
    fill_len   = 13'd7;
    fill_color = 24'h123456;
    for (int i = 1; i <= 17; i++) begin
      @(negedge clk);
      fill_start = 1'b0;
      if (cpu_ack === 1'b1) acks++;
      checks++;
      if (i % 2 == 1) begin
        if ({web, cpu_ack, addrb, datab, fill_done, fill_busy} !==
            {1'b1, 1'b1, 13'h0200 + ncpu[12:0], 24'h100000 + ncpu[23:0], 1'b0, (i < 16)}) begin
          errors++;
          $display("FAIL contend_cpu[%0d] got web=%0b ack=%0b addrb=%h datab=%h done=%0b busy=%0b exp cpu write %0d",
                   i, web, cpu_ack, addrb, datab, fill_done, fill_busy, ncpu);
        end
        ncpu++;
        if (i == 17) begin
          cpu_req = 1'b0;
        end else begin
          cpu_addr = 13'h0200 + ncpu[12:0];
          cpu_data = 24'h100000 + ncpu[23:0];
        end
      end else begin
        j = i / 2 - 1;
        if ({web, cpu_ack, addrb, datab, fill_done, fill_busy} !==
            {1'b1, 1'b0, 13'h0100 + j[12:0], 24'h123456, (i == 16), (i < 16)}) begin
          errors++;
          $display("FAIL contend_fill[%0d] got web=%0b ack=%0b addrb=%h datab=%h done=%0b busy=%0b exp fill word %0d",
                   i, web, cpu_ack, addrb, datab, fill_done, fill_busy, j);
        end
      end
    end
    @(negedge clk);
    checks++;
    if ({web, cpu_ack, acks} !== {1'b0, 1'b0, 32'd9}) begin
      errors++;
      $display("FAIL contend_end got web=%0b ack=%0b acks=%0d exp 0 0 9", web, cpu_ack, acks);
    end
`ifdef VMEM_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 16'd0) begin
      errors++;
      $display("FAIL contend_stall got=%0d exp=0", stall_cnt);
    end
`endif
  endtask

  task automatic test_fill_start_busy;
    int writes;
    int dones;
    int k;
    writes = 0;
    dones  = 0;
    fill_start = 1'b1;
    fill_base  = 13'h0500;
    fill_len   = 13'd7;
    fill_color = 24'hAAAAAA;
    @(negedge clk);
    fill_start = 1'b0;
    for (int i = 2; i <= 12; i++) begin
      @(negedge clk);
      if (web === 1'b1) writes++;
      if (fill_done === 1'b1) dones++;
      checks++;
      if (i <= 9) begin
        k = i - 2;
        if ({web, addrb, datab, fill_done} !== {1'b1, 13'h0500 + k[12:0], 24'hAAAAAA, (i == 9)}) begin
          errors++;
          $display("FAIL busy_fill[%0d] got web=%0b addrb=%h datab=%h done=%0b exp addrb=%h done=%0b",
                   i, web, addrb, datab, fill_done, 13'h0500 + k[12:0], (i == 9));
        end
      end else begin
        if ({web, fill_done, fill_busy} !== 3'b000) begin
          errors++;
          $display("FAIL busy_idle[%0d] got web=%0b done=%0b busy=%0b exp 0 0 0",
                   i, web, fill_done, fill_busy);
        end
      end
      if (i == 3) begin
        fill_start = 1'b1;
        fill_base  = 13'h0700;
        fill_len   = 13'd2;
        fill_color = 24'h555555;
      end else begin
        fill_start = 1'b0;
      end
    end
    checks++;
    if ({writes, dones} !== {32'd8, 32'd1}) begin
      errors++;
      $display("FAIL busy_totals got writes=%0d dones=%0d exp 8 1", writes, dones);
    end
  endtask

  task automatic test_reset_mid_fill;
    fill_start = 1'b1;
    fill_base  = 13'h0A00;
    fill_len   = 13'd7;
    fill_color = 24'h0F0F0F;
    @(negedge clk);
    fill_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if ({web, addrb, fill_done} !== {1'b1, 13'h0A00 + k[12:0], 1'b0}) begin
        errors++;
        $display("FAIL rst_pre[%0d] got web=%0b addrb=%h done=%0b exp 1 %h 0",
                 k, web, addrb, fill_done, 13'h0A00 + k[12:0]);
      end
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({web, fill_busy, fill_done, cpu_ack, addrb, datab} !== 41'd0) begin
      errors++;
      $display("FAIL rst_async got web=%0b busy=%0b done=%0b ack=%0b addrb=%h datab=%h exp all zero",
               web, fill_busy, fill_done, cpu_ack, addrb, datab);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if ({web, fill_busy, fill_done} !== 3'b000) begin
        errors++;
        $display("FAIL rst_hold[%0d] got web=%0b busy=%0b done=%0b exp 0 0 0",
                 k, web, fill_busy, fill_done);
      end
    end
    rst_n      = 1'b1;
    fill_start = 1'b1;
    fill_base  = 13'h0C00;
    fill_len   = 13'd1;
    fill_color = 24'h00000F;
    @(negedge clk);
    fill_start = 1'b0;
    checks++;
    if ({web, fill_busy} !== 2'b01) begin
      errors++;
      $display("FAIL rst_refill_latch got web=%0b busy=%0b exp 0 1", web, fill_busy);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if ({web, addrb, datab, fill_done} !== {1'b1, 13'h0C00 + k[12:0], 24'h00000F, (k == 1)}) begin
        errors++;
        $display("FAIL rst_refill[%0d] got web=%0b addrb=%h datab=%h done=%0b exp addrb=%h done=%0b",
                 k, web, addrb, datab, fill_done, 13'h0C00 + k[12:0], (k == 1));
      end
    end
    @(negedge clk);
    checks++;
    if ({web, fill_busy, fill_done} !== 3'b000) begin
      errors++;
      $display("FAIL rst_refill_end got web=%0b busy=%0b done=%0b exp 0 0 0", web, fill_busy, fill_done);
    end
  endtask

  initial begin
    errors     = 0;
    checks     = 0;
    clk        = 1'b0;
    rst_n      = 1'b0;
    cpu_req    = 1'b0;
    cpu_addr   = '0;
    cpu_data   = '0;
    fill_start = 1'b0;
    fill_base  = '0;
    fill_len   = '0;
    fill_color = '0;
    test_reset();
    test_cpu_only();
    test_fill_wrap();
    test_contention();
    test_fill_start_busy();
    test_reset_mid_fill();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vmem_write_arbiter.md
VMEM_WRITE_ARBITER -- requirements
Module: vmem_write_arbiter

Interface
REQ-001 Parameter ADDR_W, 13, video memory address width (8192 words) SHALL be provided.
REQ-002 Parameter DATA_W, 24, pixel word width SHALL be provided.
REQ-003 clk  in  1  single clock for all state SHALL be provided.
REQ-004 rst_n  in  1  reset, asynchronous, active-low SHALL be provided.
REQ-005 cpu_req  in  1  CPU write request, held with addr/data stable until cpu_ack SHALL be provided.
REQ-006 cpu_addr  in  ADDR_W  and cpu_data  in  DATA_W  CPU write address/data SHALL be provided.
REQ-007 cpu_ack  out  1  one-cycle pulse, CPU write issued SHALL be provided.
REQ-008 fill_start  in  1  one-cycle fill command pulse SHALL be provided.
REQ-009 fill_base  in  ADDR_W, fill_len  in  ADDR_W (words minus 1), fill_color  in  DATA_W SHALL be provided.
REQ-010 fill_busy  out  1  fill in progress; fill_done  out  1  one-cycle completion pulse SHALL be provided.
REQ-011 web  out  1, addrb  out  ADDR_W, datab  out  DATA_W  memory write port, all registered, SHALL be provided.

Function
REQ-012 Block SHALL share the memory write port between CPU writes and a hardware fill engine; at most one write per cycle.
REQ-013 FSM SHALL have states IDLE and FILL; IDLE->FILL on fill_start; FILL->IDLE in the cycle the last fill write is registered.
REQ-014 In IDLE, fill_start SHALL latch base, color, remaining count = fill_len+1; first fill write SHALL be issued no earlier than next cycle.
REQ-015 fill_start while fill_busy=1 SHALL be ignored.
REQ-016 Fill addresses SHALL increment from base modulo 2^ADDR_W (8191 wraps to 0); fill_len=8191 writes all 8192 words exactly once.
REQ-017 CPU SHALL be eligible when cpu_req=1 and cpu_ack=0 (no grant in the ack cycle; max CPU rate 1 write / 2 cycles).
REQ-018 In IDLE an eligible CPU SHALL always be granted.
REQ-019 In FILL with eligible CPU, grant SHALL go to CPU if previous grant was fill or no grant, else to fill (strict alternation, CPU first).
REQ-020 A grant at edge t SHALL produce web=1, addrb/datab at edge t+1 (latency 1); cpu_ack SHALL be high in the same cycle as the CPU's web.
REQ-021 fill_done SHALL pulse in the cycle the final fill write's web is high; fill_busy SHALL drop in that same cycle.
REQ-022 When no grant, web SHALL be 0; addrb/datab SHALL hold previous values.
REQ-023 fill_start and cpu_req in the same IDLE cycle: CPU granted, fill latched; fill begins next cycle under REQ-019.

Reset
REQ-024 rst_n low SHALL asynchronously force IDLE, web=0, addrb=0, datab=0, cpu_ack=0, fill_busy=0, fill_done=0, count=0.
REQ-025 Reset during FILL SHALL abort the fill with no further writes and no fill_done pulse.
REQ-026 After rst_n rises, first grant SHALL be possible on the first clk edge.

Configuration
REQ-027 Macro VMEM_STALL_CNT_EN defined: output stall_cnt  out  16 SHALL count cycles with cpu_req=1, cpu_ack=0 and CPU not granted, saturating at 65535, reset to 0.
REQ-028 Macro VMEM_STALL_CNT_EN undefined: stall_cnt port and counter SHALL be absent; all other behaviour identical.

Verification
REQ-029 CPU only: cpu_req held, addr=0x0010, data=0xABCDEF -> web=1, addrb=0x0010, datab=0xABCDEF, cpu_ack=1 one cycle after request; no duplicate write.
REQ-030 Fill only: base=0x1FFE, len=3, color=0x00FF00 -> writes 0x1FFE,0x1FFF,0x0000,0x0001 on consecutive cycles; fill_done with last write.
REQ-031 Contention: fill len=7 running, cpu_req held continuously -> web every cycle, grants alternate CPU/fill; fill finishes in <=16 cycles; every CPU write acked exactly once.
REQ-032 fill_start during busy: second pulse mid-fill -> ignored; exactly len+1 writes, one fill_done.
REQ-033 Reset mid-fill: rst_n low after 3 of 8 writes -> web=0 immediately, fill_busy=0, no fill_done; new fill after reset runs normally.
REQ-034 VMEM_STALL_CNT_EN: CPU held during contention for 10 cycles -> stall_cnt equals count of non-granted, non-ack cycles; forced 70000 stall cycles -> stall_cnt=65535.
